// File: rtl/rv32_pkg.sv
// Shared RV32I decode types and constants.
//   alu_op_e      : operation requested from the execute stage.
//   instr_class_e : one-hot instruction class; ClassNone marks an illegal encoding.
//   OPC_*         : major opcodes (instr[6:0]).
//   *_MASK        : class sets that read rs1 / read rs2 / write rd.
package rv32_pkg;

  typedef enum logic [4:0] {
    AluAdd, AluSub, AluSlt, AluSltu, AluXor, AluOr, AluAnd, AluSll, AluSrl, AluSra,
    AluEq, AluNe, AluLt, AluGe, AluLtu, AluGeu, AluPassB
  } alu_op_e;

  typedef enum logic [10:0] {
    ClassNone   = 11'h000,
    ClassLui    = 11'h001,
    ClassAuipc  = 11'h002,
    ClassJal    = 11'h004,
    ClassJalr   = 11'h008,
    ClassBranch = 11'h010,
    ClassLoad   = 11'h020,
    ClassStore  = 11'h040,
    ClassOpimm  = 11'h080,
    ClassOp     = 11'h100,
    ClassFence  = 11'h200,
    ClassSystem = 11'h400
  } instr_class_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [10:0] USES_RS1_MASK = ClassJalr | ClassBranch | ClassLoad | ClassStore |
                                          ClassOpimm | ClassOp;
  localparam logic [10:0] USES_RS2_MASK = ClassBranch | ClassStore | ClassOp;
  localparam logic [10:0] WRITES_RD_MASK = ClassLui | ClassAuipc | ClassJal | ClassJalr |
                                           ClassLoad | ClassOpimm | ClassOp;

  function automatic logic class_in(input instr_class_e cls, input logic [10:0] mask);
    return |(cls & mask);
  endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational immediate selection for RV32I, keyed by the decoded class.
//   i_instr : instruction bits [31:7] (opcode bits are not needed here)
//   i_class : one-hot class from the decoder
//   o_imm   : sign-extended immediate, 0 for classes without one
module rv32_imm_gen
  import rv32_pkg::*;
(
  input  logic [31:7]  i_instr,
  input  instr_class_e i_class,
  output logic [31:0]  o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_class)
      ClassJalr, ClassLoad, ClassOpimm: begin
        o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      ClassStore: begin
        o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      ClassBranch: begin
        o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      end
      ClassLui, ClassAuipc: begin
        o_imm = {i_instr[31:12], 12'h000};
      end
      ClassJal: begin
        o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21],
                 1'b0};
      end
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage between fetch and execute.
// Decodes instr_i combinationally, registers the result, and raises stall_o for one cycle
// on a load-use hazard against the instruction currently held in the output registers.
//   clk, rst          : clock, asynchronous active-high reset
//   instr_i, pc_i     : instruction and PC from fetch, valid when clk_en_i
//   stall_i, flush_i  : downstream stall, stage flush (flush wins)
//   pc_o .. illegal_o : registered decode results for execute
//   clk_en_o          : execute clock enable (0 = bubble)
//   stall_o           : load-use stall request to fetch / stall tree
module decode_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] PC_RESET     = 32'h0000_0000,
  parameter bit          CHECK_FUNCT7 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  instr_i,
  input  logic [31:0]  pc_i,
  input  logic         clk_en_i,
  output logic [31:0]  pc_o,
  output logic [31:0]  instr_o,
  output logic [4:0]   rs1_addr_o,
  output logic [4:0]   rs2_addr_o,
  output logic [4:0]   rd_addr_o,
  output logic [31:0]  imm_o,
  output logic [2:0]   funct3_o,
  output alu_op_e      alu_op_o,
  output instr_class_e instr_class_o,
  output logic         illegal_o,
  output logic         clk_en_o,
  output logic         stall_o,
  input  logic         stall_i,
  input  logic         flush_i
);

  logic [6:0]   w_opcode;
  logic [2:0]   w_funct3;
  logic [6:0]   w_funct7;
  instr_class_e w_class_raw;
  instr_class_e w_class;
  logic         w_bad;
  logic         w_uses_rs1;
  logic         w_uses_rs2;
  logic [4:0]   w_rs1;
  logic [4:0]   w_rs2;
  logic [4:0]   w_rd;
  logic [31:0]  w_imm;
  alu_op_e      w_alu;
  logic         w_stall;
  logic         w_advance;
  logic         w_load;

  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [4:0]   r_rs1;
  logic [4:0]   r_rs2;
  logic [4:0]   r_rd;
  logic [31:0]  r_imm;
  logic [2:0]   r_funct3;
  alu_op_e      r_alu;
  instr_class_e r_class;
  logic         r_illegal;
  logic         r_clk_en;
  logic         r_load_pending;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];

  // Class and legality.
  always_comb begin
    w_class_raw = ClassNone;
    w_bad       = 1'b0;
    if (w_opcode[1:0] != 2'b11) begin
      w_bad = 1'b1;
    end else begin
      case (w_opcode)
        OPC_LUI:    w_class_raw = ClassLui;
        OPC_AUIPC:  w_class_raw = ClassAuipc;
        OPC_JAL:    w_class_raw = ClassJal;
        OPC_FENCE:  w_class_raw = ClassFence;
        OPC_SYSTEM: w_class_raw = ClassSystem;
        OPC_JALR: begin
          w_class_raw = ClassJalr;
          w_bad       = (w_funct3 != 3'b000);
        end
        OPC_BRANCH: begin
          w_class_raw = ClassBranch;
          w_bad       = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
        end
        OPC_LOAD: begin
          w_class_raw = ClassLoad;
          w_bad       = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
        end
        OPC_STORE: begin
          w_class_raw = ClassStore;
          w_bad       = (w_funct3 >= 3'b011);
        end
        OPC_OPIMM: begin
          w_class_raw = ClassOpimm;
          if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) begin
            w_bad = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
            // SLLI has no alternate form, so 0x20 there is a reserved encoding.
            if (CHECK_FUNCT7 && (w_funct3 == 3'b001) && (w_funct7 != 7'h00)) begin
              w_bad = 1'b1;
            end
          end
        end
        OPC_OP: begin
          w_class_raw = ClassOp;
          if (CHECK_FUNCT7) begin
            w_bad = !((w_funct7 == 7'h00) ||
                      ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
          end
        end
        default: w_bad = 1'b1;
      endcase
    end
    w_class = w_bad ? ClassNone : w_class_raw;
  end

  // Unused register fields are zeroed so x0 can never match a pending load.
  assign w_uses_rs1 = class_in(w_class, USES_RS1_MASK);
  assign w_uses_rs2 = class_in(w_class, USES_RS2_MASK);
  assign w_rs1      = w_uses_rs1 ? instr_i[19:15] : 5'd0;
  assign w_rs2      = w_uses_rs2 ? instr_i[24:20] : 5'd0;
  assign w_rd       = class_in(w_class, WRITES_RD_MASK) ? instr_i[11:7] : 5'd0;

  always_comb begin
    w_alu = AluAdd;
    case (w_class)
      ClassLui: w_alu = AluPassB;
      ClassBranch: begin
        case (w_funct3)
          3'b000:  w_alu = AluEq;
          3'b001:  w_alu = AluNe;
          3'b100:  w_alu = AluLt;
          3'b101:  w_alu = AluGe;
          3'b110:  w_alu = AluLtu;
          3'b111:  w_alu = AluGeu;
          default: w_alu = AluAdd;
        endcase
      end
      ClassOpimm, ClassOp: begin
        case (w_funct3)
          3'b000:  w_alu = ((w_class == ClassOp) && w_funct7[5]) ? AluSub : AluAdd;
          3'b001:  w_alu = AluSll;
          3'b010:  w_alu = AluSlt;
          3'b011:  w_alu = AluSltu;
          3'b100:  w_alu = AluXor;
          3'b101:  w_alu = w_funct7[5] ? AluSra : AluSrl;
          3'b110:  w_alu = AluOr;
          default: w_alu = AluAnd;
        endcase
      end
      default: w_alu = AluAdd;
    endcase
  end

  rv32_imm_gen u_imm_gen (
    .i_instr (instr_i[31:7]),
    .i_class (w_class),
    .o_imm   (w_imm)
  );

  // The stall bubble clears load_pending, so a hazard can only stall once.
  assign w_stall = clk_en_i & r_load_pending & r_clk_en & ~flush_i &
                   ((w_uses_rs1 & (w_rs1 == r_rd)) | (w_uses_rs2 & (w_rs2 == r_rd)));

  assign w_advance = ~flush_i & ~stall_i & ~w_stall;
  assign w_load    = w_advance & clk_en_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_en       <= 1'b0;
      r_load_pending <= 1'b0;
    end else if (flush_i) begin
      r_clk_en       <= 1'b0;
      r_load_pending <= 1'b0;
    end else if (!stall_i) begin
      r_clk_en       <= w_load;
      r_load_pending <= w_load & (w_class == ClassLoad) & (w_rd != 5'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= PC_RESET;
      r_instr   <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_funct3  <= '0;
      r_alu     <= AluAdd;
      r_class   <= ClassNone;
      r_illegal <= 1'b0;
    end else if (w_load) begin
      r_pc      <= pc_i;
      r_instr   <= instr_i;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_rd      <= w_rd;
      r_imm     <= w_imm;
      r_funct3  <= w_funct3;
      r_alu     <= w_alu;
      r_class   <= w_class;
      r_illegal <= w_bad;
    end
  end

  assign pc_o          = r_pc;
  assign instr_o       = r_instr;
  assign rs1_addr_o    = r_rs1;
  assign rs2_addr_o    = r_rs2;
  assign rd_addr_o     = r_rd;
  assign imm_o         = r_imm;
  assign funct3_o      = r_funct3;
  assign alu_op_o      = r_alu;
  assign instr_class_o = r_class;
  assign illegal_o     = r_illegal;
  assign clk_en_o      = r_clk_en;
  assign stall_o       = w_stall;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases with literal expectations, then
// randomized traffic checked every cycle against a behavioural reference model.
module tb_decode_stage;
  import rv32_pkg::*;

  localparam logic [31:0] PC_RST   = 32'h0000_1000;
  localparam bit          CHECK_F7 = 1'b1;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [4:0]  alu;
    logic [10:0] cls;
    logic        ill;
    logic        u1;
    logic        u2;
  } exp_t;

  localparam alu_op_e ARITH_TAB [8] = '{AluAdd, AluSll, AluSlt, AluSltu, AluXor, AluSrl,
                                        AluOr, AluAnd};
  localparam alu_op_e BR_TAB [8] = '{AluEq, AluNe, AluAdd, AluAdd, AluLt, AluGe, AluLtu,
                                     AluGeu};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  instr_i = '0;
  logic [31:0]  pc_i = '0;
  logic         clk_en_i = 1'b0;
  logic         stall_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [31:0]  pc_o, instr_o, imm_o;
  logic [4:0]   rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [2:0]   funct3_o;
  alu_op_e      alu_op_o;
  instr_class_e instr_class_o;
  logic         illegal_o, clk_en_o, stall_o;

  int n_checks = 0;
  int n_errors = 0;

  decode_stage #(
    .PC_RESET     (PC_RST),
    .CHECK_FUNCT7 (CHECK_F7)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .clk_en_i      (clk_en_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rd_addr_o     (rd_addr_o),
    .imm_o         (imm_o),
    .funct3_o      (funct3_o),
    .alu_op_o      (alu_op_o),
    .instr_class_o (instr_class_o),
    .illegal_o     (illegal_o),
    .clk_en_o      (clk_en_o),
    .stall_o       (stall_o),
    .stall_i       (stall_i),
    .flush_i       (flush_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t         e;
    logic [6:0]   f7;
    logic [2:0]   f3;
    logic         ok;
    instr_class_e c;
    e  = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ok = 1'b1;
    c  = ClassNone;
    case (ins[6:0])
      OPC_LUI:    c = ClassLui;
      OPC_AUIPC:  c = ClassAuipc;
      OPC_JAL:    c = ClassJal;
      OPC_FENCE:  c = ClassFence;
      OPC_SYSTEM: c = ClassSystem;
      OPC_JALR:   begin c = ClassJalr;   ok = (f3 == 0); end
      OPC_BRANCH: begin c = ClassBranch; ok = !(f3 inside {3'd2, 3'd3}); end
      OPC_LOAD:   begin c = ClassLoad;   ok = !(f3 inside {3'd3, 3'd6, 3'd7}); end
      OPC_STORE:  begin c = ClassStore;  ok = (f3 < 3); end
      OPC_OPIMM: begin
        c = ClassOpimm;
        if (f3 == 1) ok = (f7 == 0) || ((f7 == 7'h20) && !CHECK_F7);
        else if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
      end
      OPC_OP: begin
        c  = ClassOp;
        ok = !CHECK_F7 || (f7 == 0) || ((f7 == 7'h20) && (f3 inside {3'd0, 3'd5}));
      end
      default: ok = 1'b0;
    endcase
    if (!ok) c = ClassNone;
    e.ill = !ok;
    e.cls = c;
    e.f3  = f3;
    e.u1  = c inside {ClassJalr, ClassBranch, ClassLoad, ClassStore, ClassOpimm, ClassOp};
    e.u2  = c inside {ClassBranch, ClassStore, ClassOp};
    e.rs1 = e.u1 ? ins[19:15] : 5'd0;
    e.rs2 = e.u2 ? ins[24:20] : 5'd0;
    e.rd  = (c inside {ClassLui, ClassAuipc, ClassJal, ClassJalr, ClassLoad, ClassOpimm,
                       ClassOp}) ? ins[11:7] : 5'd0;
    case (c)
      ClassJalr, ClassLoad, ClassOpimm: e.imm = 32'($signed(ins[31:20]));
      ClassStore:  e.imm = 32'($signed({ins[31:25], ins[11:7]}));
      ClassBranch: e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      ClassLui, ClassAuipc: e.imm = {ins[31:12], 12'h000};
      ClassJal: e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default: e.imm = 32'd0;
    endcase
    case (c)
      ClassLui:    e.alu = AluPassB;
      ClassBranch: e.alu = BR_TAB[f3];
      ClassOp, ClassOpimm: begin
        e.alu = ARITH_TAB[f3];
        if ((f3 == 5) && f7[5]) e.alu = AluSra;
        if ((f3 == 0) && f7[5] && (c == ClassOp)) e.alu = AluSub;
      end
      default: e.alu = AluAdd;
    endcase
    return e;
  endfunction

  // Behavioural model of the stage registers.
  exp_t        cur;
  exp_t        m_d;
  logic        m_en, m_lp, m_hold, m_stall;
  logic [31:0] m_pc, m_instr;

  always_comb cur = ref_decode(instr_i);
  always_comb m_stall = clk_en_i && m_lp && m_en && !flush_i &&
                        ((cur.u1 && (cur.rs1 == m_d.rd)) || (cur.u2 && (cur.rs2 == m_d.rd)));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en <= 1'b0; m_lp <= 1'b0; m_hold <= 1'b0;
      m_pc <= PC_RST; m_instr <= '0; m_d <= '0;
    end else begin
      m_hold <= !flush_i && (stall_i || m_stall);
      if (flush_i) begin
        m_en <= 1'b0; m_lp <= 1'b0;
      end else if (stall_i) begin
        m_en <= m_en;
      end else if (m_stall) begin
        m_en <= 1'b0; m_lp <= 1'b0;
      end else begin
        m_en <= clk_en_i;
        m_lp <= clk_en_i && (cur.cls == ClassLoad) && (cur.rd != 0);
        if (clk_en_i) begin
          m_pc <= pc_i; m_instr <= instr_i; m_d <= cur;
        end
      end
    end
  end

  // Compare process: clock enable and stall every cycle, data whenever it is valid.
  always @(negedge clk) begin
    if (!rst) begin
      chk("clk_en_o", 32'(clk_en_o), 32'(m_en));
      chk("stall_o", 32'(stall_o), 32'(m_stall));
      if (m_en) begin
        chk("pc_o", pc_o, m_pc);
        chk("instr_o", instr_o, m_instr);
        chk("rs1_addr_o", 32'(rs1_addr_o), 32'(m_d.rs1));
        chk("rs2_addr_o", 32'(rs2_addr_o), 32'(m_d.rs2));
        chk("rd_addr_o", 32'(rd_addr_o), 32'(m_d.rd));
        chk("imm_o", imm_o, m_d.imm);
        chk("funct3_o", 32'(funct3_o), 32'(m_d.f3));
        chk("alu_op_o", 32'(alu_op_o), 32'(m_d.alu));
        chk("instr_class_o", 32'(instr_class_o), 32'(m_d.cls));
        chk("illegal_o", 32'(illegal_o), 32'(m_d.ill));
      end
    end
  end

  task automatic drive(input logic en, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl);
    clk_en_i = en; instr_i = ins; pc_i = pc; stall_i = st; flush_i = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 15))
      0:  r[6:0] = OPC_LUI;
      1:  r[6:0] = OPC_AUIPC;
      2:  r[6:0] = OPC_JAL;
      3:  r[6:0] = OPC_JALR;
      4:  r[6:0] = OPC_BRANCH;
      5:  r[6:0] = OPC_LOAD;
      6:  r[6:0] = OPC_STORE;
      7:  r[6:0] = OPC_OPIMM;
      8:  r[6:0] = OPC_OP;
      9:  r[6:0] = OPC_FENCE;
      10: r[6:0] = OPC_SYSTEM;
      11, 12: r[6:0] = OPC_LOAD;
      default: r[6:0] = r[6:0];
    endcase
    if ($urandom_range(0, 3) != 0) begin
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
    end
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: r[31:25] = r[31:25];
    endcase
    return r;
  endfunction

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_LW    = 32'h0001_2283;  // lw x5,0(x2)
  localparam logic [31:0] I_ADD   = 32'h0072_8333;  // add x6,x5,x7
  localparam logic [31:0] I_ADD0  = 32'h0070_0333;  // add x6,x0,x7
  localparam logic [31:0] I_BEQ   = 32'hFE00_0EE3;  // beq x0,x0,-4
  localparam logic [31:0] I_BAD   = 32'h0000_007F;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst clk_en_o", 32'(clk_en_o), 32'd0);
    chk("rst stall_o", 32'(stall_o), 32'd0);
    chk("rst illegal_o", 32'(illegal_o), 32'd0);
    chk("rst pc_o", pc_o, PC_RST);
    chk("rst imm_o", imm_o, 32'd0);
    rst = 1'b0;

    // addi x1,x0,5
    drive(1'b1, I_ADDI, 32'h100, 1'b0, 1'b0);
    tick();
    chk("addi clk_en_o", 32'(clk_en_o), 32'd1);
    chk("addi rd", 32'(rd_addr_o), 32'd1);
    chk("addi rs1", 32'(rs1_addr_o), 32'd0);
    chk("addi imm", imm_o, 32'd5);
    chk("addi alu", 32'(alu_op_o), 32'(AluAdd));
    chk("addi class", 32'(instr_class_o), 32'h080);
    chk("addi pc", pc_o, 32'h100);

    // Load-use hazard: one stall cycle, one bubble, then the add issues.
    drive(1'b1, I_LW, 32'h104, 1'b0, 1'b0);
    tick();
    chk("lw class", 32'(instr_class_o), 32'h020);
    drive(1'b1, I_ADD, 32'h108, 1'b0, 1'b0);
    chk("hazard stall_o", 32'(stall_o), 32'd1);
    tick();
    chk("bubble clk_en_o", 32'(clk_en_o), 32'd0);
    chk("stall one cycle", 32'(stall_o), 32'd0);
    tick();
    chk("add clk_en_o", 32'(clk_en_o), 32'd1);
    chk("add rs1", 32'(rs1_addr_o), 32'd5);
    chk("add rs2", 32'(rs2_addr_o), 32'd7);
    chk("add rd", 32'(rd_addr_o), 32'd6);

    // Same pair with rs1=x0: no hazard.
    drive(1'b1, I_LW, 32'h10C, 1'b0, 1'b0);
    tick();
    drive(1'b1, I_ADD0, 32'h110, 1'b0, 1'b0);
    chk("x0 no stall", 32'(stall_o), 32'd0);
    tick();
    chk("add0 clk_en_o", 32'(clk_en_o), 32'd1);
    chk("add0 pc", pc_o, 32'h110);

    // Downstream stall freezes everything for 3 cycles.
    drive(1'b1, I_ADDI, 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b1, I_ADD, 32'h204, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frozen clk_en_o", 32'(clk_en_o), 32'd1);
      chk("frozen rd", 32'(rd_addr_o), 32'd1);
      chk("frozen pc", pc_o, 32'h200);
    end
    drive(1'b1, I_ADD, 32'h204, 1'b0, 1'b0);
    tick();
    chk("release pc", pc_o, 32'h204);

    // Flush together with a hazard and stall_i.
    drive(1'b1, I_LW, 32'h208, 1'b0, 1'b0);
    tick();
    drive(1'b1, I_ADD, 32'h20C, 1'b1, 1'b1);
    chk("flush stall_o", 32'(stall_o), 32'd0);
    tick();
    chk("flush clk_en_o", 32'(clk_en_o), 32'd0);
    drive(1'b1, I_ADD, 32'h20C, 1'b0, 1'b0);
    tick();
    chk("after flush issue", 32'(clk_en_o), 32'd1);

    // Branch immediate and illegal encoding.
    drive(1'b1, I_BEQ, 32'h300, 1'b0, 1'b0);
    tick();
    chk("beq imm", imm_o, 32'hFFFF_FFFC);
    chk("beq rd", 32'(rd_addr_o), 32'd0);
    chk("beq class", 32'(instr_class_o), 32'h010);
    drive(1'b1, I_BAD, 32'h304, 1'b0, 1'b0);
    tick();
    chk("bad illegal_o", 32'(illegal_o), 32'd1);
    chk("bad rd", 32'(rd_addr_o), 32'd0);
    chk("bad class", 32'(instr_class_o), 32'd0);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("async clk_en_o", 32'(clk_en_o), 32'd0);
    chk("async stall_o", 32'(stall_o), 32'd0);
    chk("async illegal_o", 32'(illegal_o), 32'd0);
    chk("async pc_o", pc_o, PC_RST);
    tick();
    rst = 1'b0;

    // Randomized traffic; fetch holds its outputs while this stage is stalled.
    pc_i = 32'h400;
    for (int n = 0; n < 3000; n++) begin
      if (!m_hold) begin
        instr_i  = rand_instr();
        pc_i     = pc_i + 32'd4;
        clk_en_i = ($urandom_range(0, 7) != 0);
      end
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of the fetch stage.
- Accepts the aligned 32-bit RV32I instruction and PC that fetch presents under its `clk_en`. Decodes into register addresses, a sign-extended immediate, an ALU operation and an instruction class, then registers the result for the execute stage.
- Joins the same stall/flush/clock-enable bubble protocol as fetch.
- Detects load-use hazards and stalls the front end for one cycle.

Parameters:
- PC_RESET, 0, reset value of pc_o; matches fetch.
- CHECK_FUNCT7, 1, when 1, non-zero reserved funct7 bits flag illegal_o; when 0 they are ignored.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-high.
- instr_i  in  32  instruction from fetch (fetch instr_send).
- pc_i  in  32  PC of instr_i.
- clk_en_i  in  1  fetch clk_en; instr_i is valid this cycle.
- pc_o  out  32  registered PC.
- instr_o  out  32  registered raw instruction, for trap value.
- rs1_addr_o  out  5  source 1 index; 0 when unused.
- rs2_addr_o  out  5  source 2 index; 0 when unused.
- rd_addr_o  out  5  destination index; 0 when no writeback.
- imm_o  out  32  sign-extended immediate.
- funct3_o  out  3  funct3 field.
- alu_op_o  out  alu_op_e  operation for execute.
- instr_class_o  out  instr_class_e  one-hot class: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM.
- illegal_o  out  1  illegal encoding.
- clk_en_o  out  1  clock enable for execute.
- stall_o  out  1  load-use stall request to fetch and the pipeline stall tree.
- stall_i  in  1  stall from downstream stages.
- flush_i  in  1  flush this stage (branch or trap).

Behaviour:

Reset (rst=1, asynchronous):
- clk_en_o=0, stall_o=0, illegal_o=0, pc_o=PC_RESET.
- All other outputs are 0. The internal load_pending flag is 0.

Decode and latency:
- Decode is combinational. Outputs are registered: one cycle from clk_en_i to clk_en_o.

Update rule, evaluated at each rising edge:
- flush_i=1: clk_en_o<=0, load_pending<=0. Data registers are don't-care. Flush overrides stall_i and stall_o.
- else stall_i=1: hold all registers, including clk_en_o and load_pending.
- else stall_o=1: clk_en_o<=0 (bubble), load_pending<=0, data registers hold. Fetch holds instr_i, so it is re-decoded next cycle.
- else: clk_en_o<=clk_en_i. When clk_en_i=1, load the data registers and set load_pending<=(class==LOAD && rd!=0). When clk_en_i=0, load_pending<=0.

Load-use hazard (stall_o):
- stall_o = clk_en_i & load_pending & clk_en_o & ((uses_rs1 & rs1==rd_addr_o) | (uses_rs2 & rs2==rd_addr_o)).
- stall_o is asserted for at most one cycle per hazard and is never asserted while flush_i=1.

Field usage:
- uses_rs1: JALR, BRANCH, LOAD, STORE, OPIMM, OP.
- uses_rs2: BRANCH, STORE, OP.
- rd is written for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP. It is forced to 0 for BRANCH, STORE, FENCE, SYSTEM, and illegal encodings.
- Unused rs fields are forced to 0, so x0 never hazards.

Immediates (bit 31 sign-extends to all 32 bits):
- I-type: instr[31:20].
- S-type: {instr[31:25], instr[11:7]}.
- B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U-type: {instr[31:12], 12'b0}.
- J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Other classes: imm_o=0.

ALU op mapping:
- OP/OPIMM: from funct3, plus funct7[5] for SUB/SRA. SUB applies to OP only.
- BRANCH: EQ, NE, LT, GE, LTU, GEU.
- LOAD, STORE, AUIPC, JAL, JALR: ADD.
- LUI: PASS_B.

Illegal (illegal_o=1, all classes 0, clk_en_o still follows the normal rule so writeback can trap):
- instr[1:0]!=2'b11.
- Unknown opcode.
- BRANCH funct3 of 010 or 011.
- LOAD funct3 of 011, 110 or 111.
- STORE funct3 >= 011.
- JALR funct3!=0.
- Shift-immediate with imm[11:5] other than 0 or 0x20.
- Reserved funct7 when CHECK_FUNCT7=1.

Decomposition:
- Package rv32_pkg holds:
  - the alu_op_e enum (ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, EQ, NE, LT, GE, LTU, GEU, PASS_B);
  - the instr_class_e one-hot typedef;
  - opcode localparams (OPC_LUI=7'b0110111, and so on).
- Sub-module rv32_imm_gen: purely combinational immediate selection, keyed by class.

Test Plan:
1. After reset, apply clk_en_i=1 with instr 0x00500093 (addi x1,x0,5) at pc_i=0x100 -> next cycle: clk_en_o=1, rd=1, rs1=0, imm=5, alu=ADD, class=OPIMM, pc_o=0x100.
2. lw x5,0(x2) followed by add x6,x5,x7 -> stall_o=1 for exactly one cycle, one bubble (clk_en_o=0), then the add issues with rs1=5, rs2=7. Repeat with add x6,x0,x7 -> no stall.
3. Apply stall_i=1 for 3 cycles mid-stream -> all outputs frozen, including clk_en_o=1. On release, the next instruction advances.
4. Assert flush_i together with a load-use hazard and stall_i=1 -> clk_en_o=0 next cycle, stall_o=0, load_pending cleared.
5. Apply beq with imm -4 (0xFE000EE3) -> imm_o=0xFFFFFFFC, rd=0, class=BRANCH. Apply instr 0x0000007F -> illegal_o=1, rd=0.
6. Assert rst asynchronously while clk_en_o=1 -> clk_en_o, stall_o and illegal_o go to 0 immediately, without waiting for a clock edge.
